lcd_reader: RTL and testbench
=============================

// Module: lcd_reader
// PURPOSE
//  HD44780-style 4-bit read engine; the read direction of the LCD bus our write controller drives.
//  Performs one RW=1 byte read: high nibble, then low nibble.
//  Reads either the busy flag/address counter (RS=0) or DDRAM/CGRAM data (RS=1).
//  Lets the system poll BF instead of using fixed 40us waits. All timing is in ns, accumulated from period_clk_ns.
// PARAMETERS
//  T_SETUP_NS      40       RS/RW setup before E rise; also RW hold after the last E fall
//  T_EH_NS         240      E high time; the nibble is sampled at the end of it
//  T_EL_NS         760      E low time between the two nibbles
//  POLL_TIMEOUT_NS 2000000  busy-poll time limit (LCD_BUSY_POLL_EN only)
// PORTS
//  clk            in   1  system clock
//  rst            in   1  asynchronous reset, active high
//  period_clk_ns  in   8  clk period in ns; 0 is treated as 1
//  strobe_in      in   1  start a read (sampled in IDLE only)
//  rs_in          in   1  0=busy flag/address, 1=data; latched at start
//  lcd_nibble_in  in   4  LCD DB7..DB4 as driven by the panel
//  lcd_e          out  1  LCD enable
//  lcd_rs         out  1  LCD register select
//  lcd_rw         out  1  1 while a read is in progress
//  lcd_nibble_oe  out  1  FPGA DB7..DB4 drive enable; 0 while the panel drives the bus
//  data_out       out  8  captured byte; held until the next capture
//  busy_flag      out  1  data_out[7] of the last RS=0 read
//  busy           out  1  1 whenever state != IDLE
//  done           out  1  one-cycle pulse when a read completes
//  timeout        out  1  one-cycle pulse together with done on poll timeout
// BEHAVIOUR
//  Reset values: lcd_e=0, lcd_rw=0, lcd_rs=0, lcd_nibble_oe=1, data_out=0, busy_flag=0, done=0, timeout=0, state=IDLE.
//  Reset takes effect immediately, including mid-read; no E pulse may be truncated into a glitch beyond the reset edge.
//  Timer rule: cnt clears on every state entry. Each cycle cnt += period_clk_ns (24-bit, saturating).
//   The state exits in the cycle where the pre-increment cnt >= T. State length is therefore ceil(T/p)+1 cycles.
//  FSM:
//   IDLE    e=0, rw=0, oe=1. On strobe_in=1: lcd_rs<=rs_in, lcd_rw<=1, oe<=0 -> SETUP.
//   SETUP   wait T_SETUP_NS; on exit lcd_e<=1 -> EH_HI.
//   EH_HI   wait T_EH_NS; on exit data_out[7:4]<=lcd_nibble_in, lcd_e<=0 -> EL_HI.
//   EL_HI   wait T_EL_NS; on exit lcd_e<=1 -> EH_LO.
//   EH_LO   wait T_EH_NS; on exit data_out[3:0]<=lcd_nibble_in, lcd_e<=0 -> HOLD.
//   HOLD    wait T_SETUP_NS; on exit lcd_rw<=0 -> DONE.
//   DONE    oe<=1, done<=1 for one cycle. If lcd_rs==0, busy_flag<=data_out[7]. -> IDLE.
//  oe rises at least one cycle after rw falls, so the FPGA and the panel never drive the bus together.
//  strobe_in is ignored outside IDLE. If strobe_in is held high, the next read starts one IDLE cycle after DONE.
//  rs_in changes mid-read have no effect. lcd_rs keeps its value after DONE.
//  With period 20ns: SETUP 3 cycles, E high 13 cycles, E low 39 cycles.
// CONFIGURATION
//  LCD_BUSY_POLL_EN defined:
//   - After HOLD, if lcd_rs==0 and data_out[7]==1, the FSM enters GAP instead of DONE.
//   - GAP waits T_EL_NS with rw held at 1 and oe at 0, then returns to SETUP.
//   - poll_cnt (32-bit) accumulates period_clk_ns from the first SETUP onward.
//   - If poll_cnt >= POLL_TIMEOUT_NS when HOLD exits, go to DONE with timeout=1.
//   - done fires only once per strobe.
//  LCD_BUSY_POLL_EN undefined: a single read per strobe; timeout is tied to 0; no GAP state.
// TESTING (clk 50MHz, period_clk_ns=20; the bench LCD model drives lcd_nibble_in only while rw=1 and e=1)
//  1 rs_in=1, model returns 0xA then 0x5.
//    -> data_out=0xA5, one done pulse, busy_flag unchanged.
//    -> e high 13 cycles twice, e low 39 cycles between; rs=1, rw=1 and oe=0 throughout.
//  2 rs_in=0, model returns 0x8/0x3 (build without macro).
//    -> data_out=0x83, busy_flag=1, timeout=0.
//  3 strobe_in pulsed again during EH_HI.
//    -> ignored; exactly one done pulse.
//    -> strobe held high gives back-to-back reads separated by one IDLE cycle.
//  4 rst asserted mid EH_LO, asynchronously to clk.
//    -> e=0, rw=0, oe=1, done=0, data_out=0 without waiting for a clk edge; the next strobe reads normally.
//  5 LCD_BUSY_POLL_EN, BF=1 for 3 reads then 0x03.
//    -> 4 reads, a single done, data_out=0x03, busy_flag=0, timeout=0.
//    -> with BF stuck at 1 and POLL_TIMEOUT_NS=20000: done and timeout pulse together, rw=0, oe=1.
//  6 period_clk_ns=10.
//    -> e high 25 cycles, e low 77 cycles, SETUP 5 cycles.
//    -> period_clk_ns=0: the read still completes (treated as 1).

Source files
------------

// File: rtl/lcd_reader.sv
module lcd_reader #(
    parameter int unsigned T_SETUP_NS      = 40,
    parameter int unsigned T_EH_NS         = 240,
    parameter int unsigned T_EL_NS         = 760,
    parameter int unsigned POLL_TIMEOUT_NS = 2000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] period_clk_ns,
    input  logic       strobe_in,
    input  logic       rs_in,
    input  logic [3:0] lcd_nibble_in,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_nibble_oe,
    output logic [7:0] data_out,
    output logic       busy_flag,
    output logic       busy,
    output logic       done,
    output logic       timeout
);

    typedef enum logic [2:0] {
        IDLE, SETUP, EH_HI, EL_HI, EH_LO, HOLD, DONE
`ifdef LCD_BUSY_POLL_EN
        , GAP
`endif
    } state_t;

    state_t      state;
    logic [23:0] cnt;
    logic [23:0] t_lim;
    logic [7:0]  p_eff;
    logic [24:0] cnt_sum;
    logic [23:0] cnt_inc;
    logic        tmr_hit;

    assign p_eff   = (period_clk_ns == 8'd0) ? 8'd1 : period_clk_ns;
    assign cnt_sum = {1'b0, cnt} + {17'd0, p_eff};
    assign cnt_inc = cnt_sum[24] ? '1 : cnt_sum[23:0];
    assign tmr_hit = (cnt >= t_lim);
    assign busy    = (state != IDLE);

`ifdef LCD_BUSY_POLL_EN
    logic [31:0] poll_cnt;
    logic [32:0] poll_sum;
    logic [31:0] poll_inc;
    logic        tmo_hit;
    logic        timeout_q;

    assign poll_sum = {1'b0, poll_cnt} + {25'd0, p_eff};
    assign poll_inc = poll_sum[32] ? '1 : poll_sum[31:0];
    assign timeout  = timeout_q;
`else
    assign timeout  = 1'b0;
`endif

    always_comb begin
        t_lim = 24'(T_SETUP_NS);
        case (state)
            EH_HI, EH_LO: t_lim = 24'(T_EH_NS);
            EL_HI:        t_lim = 24'(T_EL_NS);
`ifdef LCD_BUSY_POLL_EN
            GAP:          t_lim = 24'(T_EL_NS);
`endif
            default:      t_lim = 24'(T_SETUP_NS);
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            lcd_e         <= 1'b0;
            lcd_rs        <= 1'b0;
            lcd_rw        <= 1'b0;
            lcd_nibble_oe <= 1'b1;
            data_out      <= '0;
            busy_flag     <= 1'b0;
            done          <= 1'b0;
`ifdef LCD_BUSY_POLL_EN
            poll_cnt      <= '0;
            tmo_hit       <= 1'b0;
            timeout_q     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            cnt  <= cnt_inc;
`ifdef LCD_BUSY_POLL_EN
            timeout_q <= 1'b0;
            poll_cnt  <= poll_inc;
`endif
            case (state)
                IDLE: begin
                    cnt           <= '0;
                    lcd_e         <= 1'b0;
                    lcd_rw        <= 1'b0;
                    lcd_nibble_oe <= 1'b1;
`ifdef LCD_BUSY_POLL_EN
                    poll_cnt      <= '0;
                    tmo_hit       <= 1'b0;
`endif
                    if (strobe_in) begin
                        lcd_rs        <= rs_in;
                        lcd_rw        <= 1'b1;
                        lcd_nibble_oe <= 1'b0;
                        state         <= SETUP;
                    end
                end
                SETUP: if (tmr_hit) begin
                    cnt   <= '0;
                    lcd_e <= 1'b1;
                    state <= EH_HI;
                end
                EH_HI: if (tmr_hit) begin
                    cnt           <= '0;
                    data_out[7:4] <= lcd_nibble_in;
                    lcd_e         <= 1'b0;
                    state         <= EL_HI;
                end
                EL_HI: if (tmr_hit) begin
                    cnt   <= '0;
                    lcd_e <= 1'b1;
                    state <= EH_LO;
                end
                EH_LO: if (tmr_hit) begin
                    cnt           <= '0;
                    data_out[3:0] <= lcd_nibble_in;
                    lcd_e         <= 1'b0;
                    state         <= HOLD;
                end
                HOLD: if (tmr_hit) begin
                    cnt <= '0;
`ifdef LCD_BUSY_POLL_EN
                    if (poll_cnt >= POLL_TIMEOUT_NS) begin
                        tmo_hit <= 1'b1;
                        lcd_rw  <= 1'b0;
                        state   <= DONE;
                    end else if (!lcd_rs && data_out[7]) begin
                        state <= GAP;
                    end else begin
                        lcd_rw <= 1'b0;
                        state  <= DONE;
                    end
`else
                    lcd_rw <= 1'b0;
                    state  <= DONE;
`endif
                end
                DONE: begin
                    cnt           <= '0;
                    lcd_nibble_oe <= 1'b1;
                    done          <= 1'b1;
                    if (!lcd_rs) busy_flag <= data_out[7];
`ifdef LCD_BUSY_POLL_EN
                    timeout_q     <= tmo_hit;
`endif
                    state         <= IDLE;
                end
`ifdef LCD_BUSY_POLL_EN
                GAP: if (tmr_hit) begin
                    cnt   <= '0;
                    state <= SETUP;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_reader.sv
module tb_lcd_reader;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] period_clk_ns = 8'd20;
    logic       strobe_in = 1'b0;
    logic       rs_in = 1'b0;
    logic [3:0] lcd_nibble_in;
    logic       lcd_e, lcd_rs, lcd_rw, lcd_nibble_oe;
    logic [7:0] data_out;
    logic       busy_flag, busy, done, timeout;

    lcd_reader #(.POLL_TIMEOUT_NS(20000)) dut (
        .clk(clk), .rst(rst), .period_clk_ns(period_clk_ns),
        .strobe_in(strobe_in), .rs_in(rs_in), .lcd_nibble_in(lcd_nibble_in),
        .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
        .lcd_nibble_oe(lcd_nibble_oe), .data_out(data_out),
        .busy_flag(busy_flag), .busy(busy), .done(done), .timeout(timeout)
    );

    always #10 clk = ~clk;

    logic [7:0] resp [0:7];
    int         nresp = 1;
    logic       model_clr = 1'b0;
    int         e_rises = 0;
    logic       e_prev = 1'b0;
    logic [3:0] nib;

    always @(posedge clk) begin
        if (model_clr) e_rises <= 0;
        else if (lcd_e && !e_prev) e_rises <= e_rises + 1;
        e_prev <= lcd_e;
    end

    always_comb begin
        int idx, bi;
        logic [7:0] b;
        idx = (e_rises > 0) ? e_rises - 1 : 0;
        bi  = idx / 2;
        if (bi > nresp - 1) bi = nresp - 1;
        b   = resp[bi];
        nib = (idx % 2 == 1) ? b[3:0] : b[7:4];
    end

    assign lcd_nibble_in = (lcd_rw && lcd_e && e_rises != 0) ? nib : 4'h0;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    int   n_hi, setup_len, lo_len, bad, n_done, n_tmo, n_both, n_start, idle_gap;
    int   hi_len [0:15];
    logic exp_rs, prev_e, prev_busy, rw_at_done, oe_at_done;

    task automatic clr_stats(input logic rs);
        n_hi = 0; setup_len = 0; lo_len = 0; bad = 0; n_done = 0;
        n_tmo = 0; n_both = 0; n_start = 0; idle_gap = 0;
        for (int i = 0; i < 16; i++) hi_len[i] = 0;
        exp_rs = rs; prev_e = 1'b0; prev_busy = 1'b0;
        rw_at_done = 1'b1; oe_at_done = 1'b0;
    endtask

    task automatic watch(input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            if (busy && !prev_busy) n_start++;
            if (lcd_e) begin
                if (!prev_e) n_hi++;
                if (n_hi <= 16) hi_len[n_hi-1]++;
                if (!(lcd_rw && !lcd_nibble_oe && lcd_rs == exp_rs)) bad++;
            end else begin
                if (n_hi == 0 && busy) setup_len++;
                if (n_hi == 1) begin
                    lo_len++;
                    if (!(lcd_rw && !lcd_nibble_oe && lcd_rs == exp_rs)) bad++;
                end
            end
            if (done) begin
                n_done++;
                rw_at_done = lcd_rw;
                oe_at_done = lcd_nibble_oe;
            end
            if (timeout) n_tmo++;
            if (done && timeout) n_both++;
            if (!busy && n_done >= 1 && n_start == 1) idle_gap++;
            prev_e    = lcd_e;
            prev_busy = busy;
        end
    endtask

    task automatic model_load(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3, input int n);
        resp[0] = b0; resp[1] = b1; resp[2] = b2; resp[3] = b3;
        for (int i = 4; i < 8; i++) resp[i] = b3;
        nresp = n;
        @(negedge clk); model_clr = 1'b1;
        @(negedge clk); model_clr = 1'b0;
    endtask

    task automatic start_read(input logic rs);
        clr_stats(rs);
        @(negedge clk);
        rs_in = rs; strobe_in = 1'b1;
        watch(1);
        strobe_in = 1'b0;
        rs_in = ~rs;
    endtask

    logic exp_bf;

    initial begin
        for (int i = 0; i < 8; i++) resp[i] = 8'h00;
        exp_bf = 1'b0;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_e", lcd_e, 0);
        chk("rst_rw", lcd_rw, 0);
        chk("rst_rs", lcd_rs, 0);
        chk("rst_oe", lcd_nibble_oe, 1);
        chk("rst_data", data_out, 0);
        chk("rst_bf", busy_flag, 0);
        chk("rst_done", done, 0);
        chk("rst_tmo", timeout, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;

        model_load(8'hA5, 8'hA5, 8'hA5, 8'hA5, 1);
        start_read(1'b1);
        watch(90);
        chk("t1_data", data_out, 8'hA5);
        chk("t1_ndone", n_done, 1);
        chk("t1_bf", busy_flag, exp_bf);
        chk("t1_npulse", n_hi, 2);
        chk("t1_setup", setup_len, 3);
        chk("t1_eh0", hi_len[0], 13);
        chk("t1_eh1", hi_len[1], 13);
        chk("t1_el", lo_len, 39);
        chk("t1_ctl", bad, 0);
        chk("t1_rs_kept", lcd_rs, 1);

`ifndef LCD_BUSY_POLL_EN
        model_load(8'h83, 8'h83, 8'h83, 8'h83, 1);
        start_read(1'b0);
        watch(90);
        chk("t2_data", data_out, 8'h83);
        chk("t2_bf", busy_flag, 1);
        chk("t2_tmo", n_tmo, 0);
        chk("t2_ndone", n_done, 1);
        exp_bf = 1'b1;
`endif

        model_load(8'h3C, 8'h3C, 8'h3C, 8'h3C, 1);
        start_read(1'b1);
        watch(8);
        strobe_in = 1'b1;
        watch(1);
        strobe_in = 1'b0;
        watch(100);
        chk("t3_data", data_out, 8'h3C);
        chk("t3_ndone", n_done, 1);
        chk("t3_nstart", n_start, 1);
        chk("t3_bf_kept", busy_flag, exp_bf);

        model_load(8'h12, 8'h34, 8'h34, 8'h34, 2);
        clr_stats(1'b1);
        @(negedge clk);
        rs_in = 1'b1; strobe_in = 1'b1;
        watch(76);
        strobe_in = 1'b0;
        watch(80);
        chk("t3_b2b_ndone", n_done, 2);
        chk("t3_b2b_nstart", n_start, 2);
        chk("t3_b2b_gap", idle_gap, 1);
        chk("t3_b2b_data", data_out, 8'h34);

        model_load(8'h77, 8'h77, 8'h77, 8'h77, 1);
        start_read(1'b1);
        watch(62);
        chk("t4_in_eh", lcd_e, 1);
        #3 rst = 1'b1;
        #1;
        chk("t4_e", lcd_e, 0);
        chk("t4_rw", lcd_rw, 0);
        chk("t4_oe", lcd_nibble_oe, 1);
        chk("t4_done", done, 0);
        chk("t4_data", data_out, 0);
        chk("t4_busy", busy, 0);
        #2 rst = 1'b0;
        exp_bf = 1'b0;
        model_load(8'h5A, 8'h5A, 8'h5A, 8'h5A, 1);
        start_read(1'b1);
        watch(90);
        chk("t4_after_data", data_out, 8'h5A);
        chk("t4_after_ndone", n_done, 1);
        chk("t4_after_eh", hi_len[0], 13);

`ifdef LCD_BUSY_POLL_EN
        model_load(8'h85, 8'h85, 8'h85, 8'h03, 4);
        start_read(1'b0);
        watch(450);
        chk("t5_npulse", n_hi, 8);
        chk("t5_ndone", n_done, 1);
        chk("t5_data", data_out, 8'h03);
        chk("t5_bf", busy_flag, 0);
        chk("t5_tmo", n_tmo, 0);

        model_load(8'h80, 8'h80, 8'h80, 8'h80, 1);
        start_read(1'b0);
        watch(1300);
        chk("t5_to_ndone", n_done, 1);
        chk("t5_to_both", n_both, 1);
        chk("t5_to_ntmo", n_tmo, 1);
        chk("t5_to_rw", rw_at_done, 0);
        chk("t5_to_oe", oe_at_done, 1);
        chk("t5_to_bf", busy_flag, 1);
`endif

        period_clk_ns = 8'd10;
        model_load(8'hC6, 8'hC6, 8'hC6, 8'hC6, 1);
        start_read(1'b1);
        watch(160);
        chk("t6_setup", setup_len, 5);
        chk("t6_eh0", hi_len[0], 25);
        chk("t6_el", lo_len, 77);
        chk("t6_eh1", hi_len[1], 25);
        chk("t6_data", data_out, 8'hC6);

        period_clk_ns = 8'd0;
        model_load(8'h69, 8'h69, 8'h69, 8'h69, 1);
        start_read(1'b1);
        watch(1400);
        chk("t6_p0_ndone", n_done, 1);
        chk("t6_p0_data", data_out, 8'h69);
        chk("t6_p0_eh0", hi_len[0], 241);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
